// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller on the OBI data bus.
//
// Latches per-source requests (edge or level), masks them with ENABLE, tracks
// sources already claimed by software (INSERVICE) and raises irq_o while any
// pending, enabled, not-in-service source exists. Software acknowledges with a
// CLAIM read (returns lowest eligible id, 1-based) and a CLAIM write (complete).
//
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   req/we/be/addr/wdata   OBI request side (addr[4:2] selects the register)
//   gnt/rvalid/rdata       OBI response side (gnt = req, rvalid one cycle later)
//   src_i [NSRC]    interrupt sources, already synchronous to Clk
//   irq_o           machine external interrupt to the core
//
// Register map (word offsets): 0 PENDING (R, W1C), 1 ENABLE, 2 MODE (1=edge),
//   3 CLAIM (read=claim, write=complete), 4 SWSET (W1S), others read 0.
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int          NSRC     = 8,
  parameter logic [31:0] addrBase = 32'h1A10_9000
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            req,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic            gnt,
  output logic            rvalid,
  output logic [31:0]     rdata,
  input  logic [NSRC-1:0] src_i,
  output logic            irq_o
);

  localparam logic [2:0] SEL_PENDING = 3'd0;
  localparam logic [2:0] SEL_ENABLE  = 3'd1;
  localparam logic [2:0] SEL_MODE    = 3'd2;
  localparam logic [2:0] SEL_CLAIM   = 3'd3;
  localparam logic [2:0] SEL_SWSET   = 3'd4;

  // Pending is split in two: a sticky part owned by edge mode (survives until
  // W1C/claim, including a bit left over after switching to level mode) and a
  // per-cycle part that mirrors the source in level mode.
  logic [NSRC-1:0] sticky_reg, sticky_next;
  logic [NSRC-1:0] level_reg, level_next;
  logic [NSRC-1:0] enable_reg, mode_reg;
  logic [NSRC-1:0] insvc_reg, insvc_next;
  logic [NSRC-1:0] src_q_reg;
  logic            rvalid_reg;
  logic [31:0]     rdata_reg, rdata_next;

  logic [2:0]      reg_sel;
  logic            wr_en, rd_en;
  logic [31:0]     wmask;
  logic [NSRC-1:0] wbits;
  logic [NSRC-1:0] pending, eligible;
  logic [NSRC-1:0] edge_vec, swset_vec, w1c_vec, claim_vec, complete_vec;
  logic            claim_rd, complete_wr, w1c_wr;
  logic [4:0]      claim_id;
  logic [31:0]     rd_val;
  logic            unused_bits;

  assign reg_sel     = addr[4:2];
  assign wr_en       = req & we;
  assign rd_en       = req & ~we;
  assign wmask       = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wbits       = wdata[NSRC-1:0] & wmask[NSRC-1:0];
  assign claim_rd    = rd_en && (reg_sel == SEL_CLAIM);
  // W1C and complete are whole-word operations only.
  assign w1c_wr      = wr_en && (reg_sel == SEL_PENDING) && (be == 4'hF);
  assign complete_wr = wr_en && (reg_sel == SEL_CLAIM) && (be == 4'hF);
  assign w1c_vec     = w1c_wr ? wdata[NSRC-1:0] : '0;
  assign swset_vec   = (wr_en && (reg_sel == SEL_SWSET)) ? wbits : '0;

  assign pending  = sticky_reg | level_reg;
  assign eligible = pending & enable_reg & ~insvc_reg;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    claim_id = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (eligible[k]) claim_id = 5'(k + 1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign edge_vec[gi]     = src_i[gi] & ~src_q_reg[gi];
      assign claim_vec[gi]    = claim_rd && (claim_id == 5'(gi + 1));
      assign complete_vec[gi] = complete_wr && (wdata[4:0] == 5'(gi + 1));
      // Set terms come last so a new edge or SWSET beats a clear in the same cycle.
      assign sticky_next[gi]  = (mode_reg[gi] & (edge_vec[gi] | swset_vec[gi])) |
                                (sticky_reg[gi] & ~(w1c_vec[gi] | (claim_vec[gi] & mode_reg[gi])));
      assign level_next[gi]   = ~mode_reg[gi] & (src_i[gi] | swset_vec[gi]);
      assign insvc_next[gi]   = claim_vec[gi] | (insvc_reg[gi] & ~complete_vec[gi]);
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      SEL_PENDING: rd_val = 32'(pending);
      SEL_ENABLE:  rd_val = 32'(enable_reg);
      SEL_MODE:    rd_val = 32'(mode_reg);
      SEL_CLAIM:   rd_val = 32'(claim_id);
      default:     rd_val = '0;
    endcase
    rdata_next = rd_en ? rd_val : '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sticky_reg <= '0;
      level_reg  <= '0;
      enable_reg <= '0;
      mode_reg   <= '0;
      insvc_reg  <= '0;
      src_q_reg  <= '0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      sticky_reg <= sticky_next;
      level_reg  <= level_next;
      insvc_reg  <= insvc_next;
      src_q_reg  <= src_i;
      rvalid_reg <= req;
      rdata_reg  <= rdata_next;
      if (wr_en && (reg_sel == SEL_ENABLE))
        enable_reg <= (enable_reg & ~wmask[NSRC-1:0]) | wbits;
      if (wr_en && (reg_sel == SEL_MODE))
        mode_reg <= (mode_reg & ~wmask[NSRC-1:0]) | wbits;
    end
  end

  assign gnt    = req;
  assign rvalid = rvalid_reg;
  assign rdata  = rdata_reg;
  assign irq_o  = |eligible;

  // Address bits outside the word decode and data bits above NSRC are don't-care.
  assign unused_bits = ^{addrBase, addr[31:5], addr[1:0], wdata, wmask};

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'h1A10_9000;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             req, we;
  logic [3:0]       be;
  logic [31:0]      addr, wdata;
  logic             gnt, rvalid;
  logic [31:0]      rdata;
  logic [NSRC-1:0]  src_i;
  logic             irq_o;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 0;

  irq_ctrl #(.NSRC(NSRC), .addrBase(BASE)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .src_i(src_i), .irq_o(irq_o)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model (per-source rule book) ----------------
  bit        m_pend [NSRC];
  bit        m_en   [NSRC];
  bit        m_mode [NSRC];
  bit        m_insvc[NSRC];
  bit        m_srcq [NSRC];
  bit        m_rvalid;
  bit [31:0] m_rdata;

  function automatic int m_claim_id();
    for (int k = 0; k < NSRC; k++)
      if (m_pend[k] && m_en[k] && !m_insvc[k]) return k + 1;
    return 0;
  endfunction

  function automatic bit m_irq();
    return m_claim_id() != 0;
  endfunction

  function automatic bit [31:0] m_read(input int off, input int cid);
    bit [31:0] v;
    v = 0;
    for (int k = 0; k < NSRC; k++) begin
      if (off == 0) v[k] = m_pend[k];
      if (off == 1) v[k] = m_en[k];
      if (off == 2) v[k] = m_mode[k];
    end
    if (off == 3) v = 32'(cid);
    return v;
  endfunction

  always @(posedge Clk) begin : model
    int        off, cid;
    bit [31:0] rv;
    bit        lane, is_edge, sw, w1c, clm, cmp;
    if (Rst) begin
      for (int k = 0; k < NSRC; k++) begin
        m_pend[k] = 0; m_en[k] = 0; m_mode[k] = 0; m_insvc[k] = 0; m_srcq[k] = 0;
      end
      m_rvalid = 0;
      m_rdata  = 0;
    end else begin
      off = int'(addr[4:2]);
      cid = m_claim_id();
      rv  = (req && !we) ? m_read(off, cid) : 32'h0;
      for (int k = 0; k < NSRC; k++) begin
        lane    = be[k / 8];
        is_edge = src_i[k] && !m_srcq[k];
        sw      = req && we && off == 4 && lane && wdata[k];
        w1c     = req && we && off == 0 && be == 4'hF && wdata[k];
        clm     = req && !we && off == 3 && cid == k + 1;
        cmp     = req && we && off == 3 && be == 4'hF && int'(wdata[4:0]) == k + 1;
        if (m_mode[k]) begin
          if (is_edge || sw)   m_pend[k] = 1;
          else if (w1c || clm) m_pend[k] = 0;
        end else begin
          m_pend[k] = src_i[k] || sw;
        end
        if (clm)      m_insvc[k] = 1;
        else if (cmp) m_insvc[k] = 0;
        if (req && we && off == 1 && lane) m_en[k]   = wdata[k];
        if (req && we && off == 2 && lane) m_mode[k] = wdata[k];
        m_srcq[k] = src_i[k];
      end
      m_rvalid = req;
      m_rdata  = rv;
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      check("gnt", 32'(gnt), 32'(req));
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      check("rdata", rdata, m_rdata);
      check("irq_o", 32'(irq_o), 32'(m_irq()));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] b);
    req = 1; we = 1; addr = BASE | 32'(off); wdata = d; be = b;
    tick();
    $display("write off=%02h data=%08h be=%h", off, d, b);
    req = 0; we = 0; wdata = 0; be = 4'hF;
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
    req = 1; we = 0; addr = BASE | 32'(off); be = 4'hF;
    tick();
    req = 0;
    d = rdata;
    $display("read  off=%02h data=%08h", off, d);
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    src_i = m;
    tick();
    src_i = '0;
  endtask

  logic [31:0] d;

  initial begin
    Rst = 1; req = 1; we = 0; addr = BASE | 32'h0C; be = 4'hF; wdata = 0; src_i = '0;

    // Reset held three cycles with a request present.
    tick();
    checking = 1;
    tick(); tick();
    Rst = 0; req = 0;
    check("reset_rvalid", 32'(rvalid), 0);
    check("reset_rdata", rdata, 0);
    check("reset_irq", 32'(irq_o), 0);
    bus_read(5'h00, d); check("reset_pending", d, 0);
    bus_read(5'h04, d); check("reset_enable", d, 0);
    bus_read(5'h08, d); check("reset_mode", d, 0);

    // Edge path, claim, re-pend while in service, complete.
    bus_write(5'h08, 32'hFF, 4'hF);
    bus_write(5'h04, 32'h01, 4'hF);
    pulse(8'h01);
    check("edge_irq_up", 32'(irq_o), 1);
    bus_read(5'h00, d); check("edge_pending", d, 32'h01);
    bus_read(5'h0C, d); check("edge_claim", d, 1);
    check("edge_irq_after_claim", 32'(irq_o), 0);
    pulse(8'h01);
    check("insvc_irq_held", 32'(irq_o), 0);
    bus_read(5'h00, d); check("repend", d, 32'h01);
    bus_write(5'h0C, 32'h1, 4'hF);
    check("complete_irq", 32'(irq_o), 1);
    bus_read(5'h0C, d); check("claim_again", d, 1);
    bus_write(5'h0C, 32'h1, 4'hF);

    // Priority between two simultaneous edges.
    bus_write(5'h04, 32'h0C, 4'hF);
    pulse(8'h0C);
    bus_read(5'h0C, d); check("prio_first", d, 3);
    bus_read(5'h0C, d); check("prio_second", d, 4);
    bus_read(5'h0C, d); check("prio_empty", d, 0);
    bus_write(5'h0C, 32'h3, 4'hF);
    bus_write(5'h0C, 32'h4, 4'hF);
    check("prio_irq_idle", 32'(irq_o), 0);

    // New edge collides with W1C of the same bit.
    src_i = 8'h01;
    bus_write(5'h00, 32'h1, 4'hF);
    src_i = '0;
    bus_read(5'h00, d); check("collision", d, 32'h01);
    bus_write(5'h00, 32'h1, 4'hF);
    bus_read(5'h00, d); check("w1c_clear", d, 0);

    // Level mode.
    bus_write(5'h08, 32'h00, 4'hF);
    bus_write(5'h04, 32'h02, 4'hF);
    src_i = 8'h02;
    tick(); tick();
    bus_write(5'h00, 32'h2, 4'hF);
    bus_read(5'h00, d); check("level_w1c_ignored", d, 32'h02);
    bus_read(5'h0C, d); check("level_claim", d, 2);
    check("level_irq_claimed", 32'(irq_o), 0);
    bus_write(5'h0C, 32'h2, 4'hF);
    check("level_irq_again", 32'(irq_o), 1);
    src_i = '0;
    tick();
    bus_read(5'h00, d); check("level_drop", d, 0);

    // Bus corner cases.
    bus_write(5'h04, 32'hA5, 4'hF);
    bus_read(5'h04, d); check("b2b_enable", d, 32'hA5);
    bus_write(5'h04, 32'h3C, 4'h1);
    bus_read(5'h04, d); check("byte0_write", d, 32'h3C);
    bus_write(5'h04, 32'hFFFF_FFFF, 4'h2);
    bus_read(5'h04, d); check("byte1_write", d, 32'h3C);
    bus_read(5'h18, d); check("unmapped", d, 0);
    check("unmapped_rvalid", 32'(rvalid), 1);

    // Complete with out-of-range ids.
    bus_write(5'h08, 32'hFF, 4'hF);
    bus_write(5'h04, 32'h01, 4'hF);
    pulse(8'h01);
    bus_read(5'h0C, d); check("bad_id_claim", d, 1);
    pulse(8'h01);
    bus_write(5'h0C, 32'h0, 4'hF);
    check("complete_id0", 32'(irq_o), 0);
    bus_write(5'h0C, 32'h9, 4'hF);
    check("complete_id9", 32'(irq_o), 0);
    bus_write(5'h0C, 32'h1, 4'hF);
    check("complete_id1", 32'(irq_o), 1);

    // Randomized traffic; MODE fixed per phase, sources quiet while it is set.
    for (int p = 0; p < 6; p++) begin
      Rst = 1; req = 0; src_i = '0;
      tick(); tick();
      Rst = 0;
      bus_write(5'h08, $urandom, 4'hF);
      for (int c = 0; c < 400; c++) begin
        src_i = src_i ^ NSRC'($urandom & $urandom);
        if ($urandom_range(0, 9) < 6) begin
          int off;
          req = 1;
          we  = 1'($urandom);
          off = $urandom_range(0, 7);
          if (we && off == 2) off = 3;
          addr  = BASE | 32'(off << 2);
          be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          wdata = (off == 3) ? 32'($urandom_range(0, 10)) : $urandom;
        end else begin
          req = 0;
        end
        tick();
        if (req)
          $display("rand p=%0d c=%0d we=%0d addr=%08h wdata=%08h be=%h rvalid=%0d rdata=%08h irq=%0d",
                   p, c, we, addr, wdata, be, rvalid, rdata, irq_o);
      end
      req = 0; we = 0;
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that sits between the peripheral interrupt outputs (UART, mtimer, Timer0/1) and the core's external interrupt input. It latches per-source requests as edge or level events, masks them with enable bits, and presents one `irq_o` line to the core. It resolves priority and provides a claim/complete handshake. Software reaches it over the OBI data bus, as another `bus_mux` slave alongside IO, UART and mtimer.

## Interface
- `NSRC`, 8, number of interrupt sources, 1..31; source k is id k+1.
- `addrBase`, 32'h1A10_9000, byte base address; block decodes `addr[4:2]` when `req` is asserted.
- `Clk` in 1, system clock; single clock domain.
- `Rst` in 1, reset; synchronous, active-high.
- `req` in 1, OBI request from `bus_mux` (CtrBus.req).
- `we` in 1, write enable.
- `be` in 4, byte enables.
- `addr` in 32, byte address (DatBus.addr).
- `wdata` in 32, write data.
- `gnt` out 1, grant.
- `rvalid` out 1, response valid.
- `rdata` out 32, read data.
- `src_i` in NSRC, interrupt sources; already synchronous to `Clk`.
- `irq_o` out 1, to core `irq_i[11]` (machine external).

## Operation
- Registers, word offsets from `addrBase`:
  - 0x00 PENDING: R; write-1-to-clear, edge sources only.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C CLAIM: read = claim, write = complete.
  - 0x10 SWSET: W; write-1 sets pending.
  - Bits ≥ NSRC read 0 and ignore writes.
- Byte enables apply to ENABLE, MODE and SWSET. PENDING W1C and CLAIM complete act only when `be == 4'hF`.
- Edge source: `src_q` holds `src_i` from the previous cycle. `src_i & ~src_q` sets the pending bit. The bit stays set until W1C or claim.
- Level source: the pending bit is `src_i` registered each cycle. W1C and claim do not clear it. SWSET still sets it for one cycle.
- Eligible set = `PENDING & ENABLE & ~INSERVICE`.
  - `irq_o` = OR of the eligible set, decoded from registers only (no `src_i` combinational path).
- CLAIM read:
  - Returns id = (lowest-index eligible source) + 1, or 0 if the set is empty.
  - For a nonzero id: sets INSERVICE[id-1]; clears PENDING[id-1] if that source is edge mode.
  - Empty set: no state change.
- CLAIM write (complete): wdata[4:0] = id.
  - Clears INSERVICE[id-1] if 1 ≤ id ≤ NSRC.
  - Any other id, or a source not in service, is ignored.
- INSERVICE is not software-readable except through its effect on `irq_o`/CLAIM.
- Unmapped offsets (0x14..): read 0, writes ignored, still granted and answered.
- Simultaneous events, same source, same cycle:
  - A new edge wins over W1C or claim-clear (pending ends at 1).
  - SWSET wins over W1C.
  - Clearing ENABLE does not clear PENDING.
- MODE change: takes effect next cycle. A pending bit left over from edge mode remains until cleared.

## Timing
- `gnt` = `req`, combinationally; no wait states.
- `rvalid` is asserted exactly one cycle after each granted request, reads and writes alike.
  - `rdata` is valid in that cycle and is 0 whenever `rvalid` is low.
- Read data is the register value sampled at the grant cycle. Register side-effects (claim, W1C, writes) commit at the clock edge ending the grant cycle.
- Back-to-back requests are accepted every cycle.
- Source latency: edge sampled on `src_i` in cycle n → PENDING bit set in n+1 → `irq_o` high in n+1 if enabled and not in service.
- Claim latency: a CLAIM in grant cycle n drops `irq_o` in n+1 if no other source is eligible.
- Reset (`Rst` high at a rising edge): PENDING, ENABLE, MODE, INSERVICE, `src_q`, `rvalid`, `rdata` and `irq_o` all go to 0.
  - A request granted in the reset cycle gets no `rvalid`.
  - A source already high when `Rst` deasserts counts as an edge: pending is set in the first cycle after reset.

## Test plan
- Reset: assert `Rst` 3 cycles while `req`=1 → `rvalid`=0, `rdata`=0, `irq_o`=0; after release, reads at 0x00/0x04/0x08 return 0.
- Edge path:
  - MODE=0xFF, ENABLE=0x01, pulse `src_i[0]` one cycle → PENDING=0x01; `irq_o`=1 next cycle.
  - CLAIM read returns 1 and `irq_o` falls the following cycle.
  - A second pulse sets PENDING again, but `irq_o` stays 0 until complete (write 1 to 0x0C); then `irq_o`=1.
- Priority: ENABLE=0x0C, edge pulses on sources 2 and 3 together → CLAIM returns 3 (source 2), next CLAIM returns 4, third CLAIM returns 0.
- Level mode: MODE=0, ENABLE=0x02, hold `src_i[1]`=1 → W1C 0x02 leaves PENDING=0x02. Claim returns 2; after complete with the source still high, `irq_o`=1 again; drop the source → PENDING=0 next cycle.
- Collision: an edge on source 0 in the same cycle as a W1C of bit 0 → PENDING bit 0 reads 1.
- Bus corner cases:
  - Back-to-back write ENABLE=0xA5 then read → `rdata`=0xA5 on the second `rvalid`.
  - Byte write `be`=0x2 to ENABLE changes only bits 15:8.
  - Read at offset 0x18 → 0, with `rvalid` 1 cycle later.
  - Complete with id 0 or id 9 → no change.
